// File: rtl/param_shop_if.sv
// Purchase request / response bundle for param_shop.
// The master issues buy requests; the slave (the shop) returns one response pulse per accepted request.
interface param_shop_if #(
  parameter int N_ITEMS  = 5,
  parameter int ACT_W    = 3,
  parameter int CREDIT_W = 10
);
  logic                buy_valid;
  logic                buy_ready;
  logic [ACT_W-1:0]    action_number;
  logic [CREDIT_W-1:0] credit_in;
  logic [6:0]          discount_mult;
  logic                resp_valid;
  logic                purchase_success;
  logic                err_invalid_action;
  logic                err_out_of_stock;
  logic                err_credit;
  logic [CREDIT_W-1:0] credit_out;
  logic [N_ITEMS-1:0]  grant_onehot;

  modport master (
    output buy_valid, action_number, credit_in, discount_mult,
    input  buy_ready, resp_valid, purchase_success, err_invalid_action,
           err_out_of_stock, err_credit, credit_out, grant_onehot
  );

  modport slave (
    input  buy_valid, action_number, credit_in, discount_mult,
    output buy_ready, resp_valid, purchase_success, err_invalid_action,
           err_out_of_stock, err_credit, credit_out, grant_onehot
  );
endinterface

// File: rtl/param_shop.sv
// Item shop: discounted purchase with per-item stock, three-state request/response FSM.
// Optional feature macro SHOP_RESTOCK_EN adds saturating restock ports.
module param_shop #(
  parameter int N_ITEMS    = 5,
  parameter int ACT_W      = 3,
  parameter int PRICE_W    = 10,
  parameter int CREDIT_W   = 10,
  parameter int STOCK_W    = 3,
  parameter int STOCK_INIT = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  param_shop_if.slave                bus,
  input  logic [N_ITEMS*PRICE_W-1:0] prices,
`ifdef SHOP_RESTOCK_EN
  input  logic                       restock_valid,
  input  logic [ACT_W-1:0]           restock_item,
  input  logic [STOCK_W-1:0]         restock_qty,
`endif
  output logic [N_ITEMS-1:0]         empty_mask
);

  localparam int DISC_W = PRICE_W + 7;
  localparam int CMP_W  = (DISC_W > CREDIT_W) ? DISC_W : CREDIT_W;
  localparam int SUM_W  = STOCK_W + 1;
  localparam logic [STOCK_W-1:0] STOCK_ZERO = {STOCK_W{1'b0}};
  localparam logic [STOCK_W-1:0] STOCK_MAX  = {STOCK_W{1'b1}};
  localparam logic [STOCK_W-1:0] STOCK_RST  = STOCK_W'(STOCK_INIT);
  localparam logic [N_ITEMS-1:0] GRANT_ONE  = N_ITEMS'(1'b1);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, RESP = 2'd2} state_t;

  state_t              state_r, state_next_s;
  logic [ACT_W-1:0]    action_r;
  logic [CREDIT_W-1:0] credit_r;
  logic [6:0]          mult_r;
  logic [PRICE_W-1:0]  price_r;
  logic [DISC_W-1:0]   disc_r;
  logic [STOCK_W-1:0]  stock_r      [N_ITEMS];
  logic [STOCK_W-1:0]  stock_next_s [N_ITEMS];
  logic [SUM_W-1:0]    stock_sum_s  [N_ITEMS];
  logic [N_ITEMS-1:0]  empty_mask_r;

  logic                resp_valid_r, success_r, err_inv_r, err_oos_r, err_cr_r;
  logic [CREDIT_W-1:0] credit_out_r;
  logic [N_ITEMS-1:0]  grant_r;

  logic [PRICE_W-1:0]  price_sel_s;
  logic [6:0]          mult_eff_s;
  logic [STOCK_W-1:0]  sel_stock_s;
  logic                ok_s, err_inv_s, err_oos_s, err_cr_s;
  logic [CREDIT_W-1:0] credit_new_s;
  logic [N_ITEMS-1:0]  grant_new_s;
  logic                accept_s;

  function automatic logic in_range(input logic [ACT_W-1:0] a);
    return ({1'b0, a} < (ACT_W+1)'(N_ITEMS));
  endfunction

  assign accept_s       = bus.buy_valid && (state_r == IDLE);
  assign bus.buy_ready  = (state_r == IDLE);
  assign bus.resp_valid         = resp_valid_r;
  assign bus.purchase_success   = success_r;
  assign bus.err_invalid_action = err_inv_r;
  assign bus.err_out_of_stock   = err_oos_r;
  assign bus.err_credit         = err_cr_r;
  assign bus.credit_out         = credit_out_r;
  assign bus.grant_onehot       = grant_r;
  assign empty_mask             = empty_mask_r;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_next_s;
  end

  // Next-state logic; requests outside IDLE are simply not accepted
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE:    if (bus.buy_valid) state_next_s = CALC; else state_next_s = IDLE;
      CALC:    state_next_s = RESP;
      RESP:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Price lookup and multiplier clamp; invalid actions read a zero price
  always_comb begin
    price_sel_s = {PRICE_W{1'b0}};
    if (in_range(bus.action_number))
      price_sel_s = prices[int'(bus.action_number)*PRICE_W +: PRICE_W];
    else
      price_sel_s = {PRICE_W{1'b0}};
    mult_eff_s = (mult_r > 7'd100) ? 7'd100 : mult_r;
  end

  // Request latch at acceptance and discounted price in CALC
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      action_r <= {ACT_W{1'b0}};
      credit_r <= {CREDIT_W{1'b0}};
      mult_r   <= 7'd0;
      price_r  <= {PRICE_W{1'b0}};
      disc_r   <= {DISC_W{1'b0}};
    end else begin
      if (accept_s) begin
        action_r <= bus.action_number;
        credit_r <= bus.credit_in;
        mult_r   <= bus.discount_mult;
        price_r  <= price_sel_s;
      end
      if (state_r == CALC)
        disc_r <= (DISC_W'(price_r) * DISC_W'(mult_eff_s)) / DISC_W'(7'd100);
    end
  end

  // Outcome decode in priority order: invalid action, out of stock, credit
  always_comb begin
    sel_stock_s  = STOCK_ZERO;
    ok_s         = 1'b0;
    err_inv_s    = 1'b0;
    err_oos_s    = 1'b0;
    err_cr_s     = 1'b0;
    if (in_range(action_r)) sel_stock_s = stock_r[action_r];
    else                    sel_stock_s = STOCK_ZERO;
    if (!in_range(action_r))                       err_inv_s = 1'b1;
    else if (sel_stock_s == STOCK_ZERO)            err_oos_s = 1'b1;
    else if (CMP_W'(disc_r) > CMP_W'(credit_r))    err_cr_s  = 1'b1;
    else                                           ok_s      = 1'b1;
    credit_new_s = ok_s ? (credit_r - CREDIT_W'(disc_r)) : credit_r;
    grant_new_s  = ok_s ? (GRANT_ONE << action_r) : {N_ITEMS{1'b0}};
  end

  // Response registers: one-cycle pulse, credit_out holds between responses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resp_valid_r <= 1'b0;
      success_r    <= 1'b0;
      err_inv_r    <= 1'b0;
      err_oos_r    <= 1'b0;
      err_cr_r     <= 1'b0;
      credit_out_r <= {CREDIT_W{1'b0}};
      grant_r      <= {N_ITEMS{1'b0}};
    end else if (state_r == RESP) begin
      resp_valid_r <= 1'b1;
      success_r    <= ok_s;
      err_inv_r    <= err_inv_s;
      err_oos_r    <= err_oos_s;
      err_cr_r     <= err_cr_s;
      credit_out_r <= credit_new_s;
      grant_r      <= grant_new_s;
    end else begin
      resp_valid_r <= 1'b0;
      success_r    <= 1'b0;
      err_inv_r    <= 1'b0;
      err_oos_r    <= 1'b0;
      err_cr_r     <= 1'b0;
      grant_r      <= {N_ITEMS{1'b0}};
    end
  end

  // Stock update: purchase decrement plus optional restock, saturated at max
  always_comb begin
    for (int i = 0; i < N_ITEMS; i++) begin
      stock_sum_s[i]  = {1'b0, stock_r[i]};
      stock_next_s[i] = stock_r[i];
      if ((state_r == RESP) && ok_s && (action_r == ACT_W'(i)))
        stock_sum_s[i] = stock_sum_s[i] - SUM_W'(1'b1);
      else
        stock_sum_s[i] = stock_sum_s[i];
`ifdef SHOP_RESTOCK_EN
      if (restock_valid && (restock_item == ACT_W'(i)))
        stock_sum_s[i] = stock_sum_s[i] + {1'b0, restock_qty};
      else
        stock_sum_s[i] = stock_sum_s[i];
`endif
      if (stock_sum_s[i] > {1'b0, STOCK_MAX}) stock_next_s[i] = STOCK_MAX;
      else                                    stock_next_s[i] = stock_sum_s[i][STOCK_W-1:0];
    end
  end

  // Stock and empty-mask registers
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_ITEMS; i++) begin
      if (!rst_n) begin
        stock_r[i]      <= STOCK_RST;
        empty_mask_r[i] <= (STOCK_RST == STOCK_ZERO);
      end else begin
        stock_r[i]      <= stock_next_s[i];
        empty_mask_r[i] <= (stock_next_s[i] == STOCK_ZERO);
      end
    end
  end

endmodule

// File: tb/tb_param_shop.sv
// Scoreboard bench for param_shop: directed purchases push expected responses, a monitor compares.
module tb_param_shop;
  localparam logic [49:0] PRICES = {10'd10, 10'd50, 10'd50, 10'd200, 10'd120};

  typedef struct packed {
    logic       succ;
    logic       inv;
    logic       oos;
    logic       cr;
    logic [9:0] credit;
    logic [4:0] grant;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [49:0] prices;
  logic [4:0]  empty_mask;
`ifdef SHOP_RESTOCK_EN
  logic        restock_valid;
  logic [2:0]  restock_item;
  logic [2:0]  restock_qty;
`endif

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  bit   started = 1'b0;

  param_shop_if #(.N_ITEMS(5), .ACT_W(3), .CREDIT_W(10)) bus ();

  param_shop dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .prices     (prices),
`ifdef SHOP_RESTOCK_EN
    .restock_valid (restock_valid),
    .restock_item  (restock_item),
    .restock_qty   (restock_qty),
`endif
    .empty_mask (empty_mask)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic exp_t mk(input bit s, input bit i, input bit o, input bit c,
                              input logic [9:0] cr, input logic [4:0] g);
    return {s, i, o, c, cr, g};
  endfunction

  // Monitor: pop and compare on every response; flags must be quiet otherwise
  always @(negedge clk) begin
    exp_t a;
    exp_t e;
    a = {bus.purchase_success, bus.err_invalid_action, bus.err_out_of_stock,
         bus.err_credit, bus.credit_out, bus.grant_onehot};
    if (started) begin
      if (bus.resp_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL resp_unexpected: got response %0h expected none", a);
        end else begin
          e = exp_q.pop_front();
          if (a !== e) begin
            errors++;
            $display("FAIL resp: got s=%0b i=%0b o=%0b c=%0b credit=%0d grant=%b expected s=%0b i=%0b o=%0b c=%0b credit=%0d grant=%b",
                     a.succ, a.inv, a.oos, a.cr, a.credit, a.grant,
                     e.succ, e.inv, e.oos, e.cr, e.credit, e.grant);
          end
        end
      end else begin
        chk("idle_quiet", 32'({a.succ, a.inv, a.oos, a.cr, a.grant}), 32'd0);
      end
    end
  end

  // Issue one request; expected response is queued before the accepting edge
  task automatic do_buy(input logic [2:0] act, input logic [9:0] cred, input logic [6:0] mult,
                        input exp_t e, input bit hold);
    prices            = PRICES;
    bus.action_number = act;
    bus.credit_in     = cred;
    bus.discount_mult = mult;
    bus.buy_valid     = 1'b1;
    chk("buy_ready_idle", 32'(bus.buy_ready), 32'd1);
    exp_q.push_back(e);
    @(posedge clk); #1;
    if (!hold) bus.buy_valid = 1'b0;
    bus.credit_in     = ~cred;
    bus.action_number = act ^ 3'd1;
    prices            = ~PRICES;
    chk("lat_calc", 32'(bus.resp_valid), 32'd0);
    if (hold) chk("ready_calc", 32'(bus.buy_ready), 32'd0);
    @(posedge clk); #1;
    chk("lat_resp_state", 32'(bus.resp_valid), 32'd0);
    if (hold) chk("ready_resp", 32'(bus.buy_ready), 32'd0);
    @(posedge clk); #1;
    bus.buy_valid = 1'b0;
    chk("lat_two_cycles", 32'(bus.resp_valid), 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_credit_out", 32'(bus.credit_out), 32'd0);
    chk("rst_empty_mask", 32'(empty_mask), 32'd0);
    chk("rst_buy_ready", 32'(bus.buy_ready), 32'd1);
  endtask

  initial begin
    logic [9:0] cr;
    bus.buy_valid     = 1'b0;
    bus.action_number = 3'd0;
    bus.credit_in     = 10'd0;
    bus.discount_mult = 7'd100;
    prices            = PRICES;
`ifdef SHOP_RESTOCK_EN
    restock_valid = 1'b0;
    restock_item  = 3'd0;
    restock_qty   = 3'd0;
`endif
    do_reset();
    started = 1'b1;

    do_buy(3'd6, 10'd1000, 7'd100, mk(0, 1, 0, 0, 10'd1000, 5'b00000), 1'b0);
    do_buy(3'd1, 10'd50,   7'd100, mk(0, 0, 0, 1, 10'd50,   5'b00000), 1'b0);
    cr = 10'd1000;
    for (int k = 0; k < 5; k++) begin
      do_buy(3'd0, cr, 7'd100, mk(1, 0, 0, 0, cr - 10'd120, 5'b00001), 1'b0);
      cr = cr - 10'd120;
    end
    chk("credit_after_five", 32'(bus.credit_out), 32'd400);
    do_buy(3'd0, 10'd400, 7'd100, mk(0, 0, 1, 0, 10'd400, 5'b00000), 1'b0);
    chk("empty_item0", 32'(empty_mask), 32'h01);
    do_buy(3'd0, 10'd0,   7'd100, mk(0, 0, 1, 0, 10'd0, 5'b00000), 1'b0);
    do_buy(3'd2, 10'd50,  7'd100, mk(1, 0, 0, 0, 10'd0, 5'b00100), 1'b0);
    do_buy(3'd4, 10'd5,   7'd0,   mk(1, 0, 0, 0, 10'd5, 5'b10000), 1'b0);
    do_buy(3'd4, 10'd5,   7'd9,   mk(1, 0, 0, 0, 10'd5, 5'b10000), 1'b0);
    @(posedge clk); #1;
    chk("credit_hold", 32'(bus.credit_out), 32'd5);

    do_reset();
    do_buy(3'd0, 10'd1000, 7'd80,  mk(1, 0, 0, 0, 10'd904, 5'b00001), 1'b0);
    do_buy(3'd0, 10'd1000, 7'd120, mk(1, 0, 0, 0, 10'd880, 5'b00001), 1'b0);
    do_buy(3'd3, 10'd100,  7'd50,  mk(1, 0, 0, 0, 10'd75,  5'b01000), 1'b1);
    repeat (3) @(posedge clk);
    #1;

    // Reset while in CALC must drop the transaction
    bus.action_number = 3'd3;
    bus.credit_in     = 10'd100;
    bus.discount_mult = 7'd50;
    bus.buy_valid     = 1'b1;
    @(posedge clk); #1;
    bus.buy_valid = 1'b0;
    rst_n         = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_resp", 32'(bus.resp_valid), 32'd0);
    chk("abort_empty_mask", 32'(empty_mask), 32'd0);
    for (int k = 0; k < 5; k++)
      do_buy(3'd3, 10'd1000, 7'd0, mk(1, 0, 0, 0, 10'd1000, 5'b01000), 1'b0);
    do_buy(3'd3, 10'd1000, 7'd0, mk(0, 0, 1, 0, 10'd1000, 5'b00000), 1'b0);
    chk("empty_item3", 32'(empty_mask), 32'h08);

`ifdef SHOP_RESTOCK_EN
    for (int k = 0; k < 5; k++)
      do_buy(3'd0, 10'd1000, 7'd100, mk(1, 0, 0, 0, 10'd880, 5'b00001), 1'b0);
    chk("drained_item0", 32'(empty_mask), 32'h09);
    fork
      do_buy(3'd2, 10'd100, 7'd100, mk(1, 0, 0, 0, 10'd50, 5'b00100), 1'b0);
      begin
        repeat (2) @(posedge clk);
        #1 restock_valid = 1'b1;
        restock_item = 3'd0;
        restock_qty  = 3'd3;
        @(posedge clk);
        #1 restock_valid = 1'b0;
      end
    join
    chk("restocked_item0", 32'(empty_mask), 32'h08);
    for (int k = 0; k < 3; k++)
      do_buy(3'd0, 10'd1000, 7'd100, mk(1, 0, 0, 0, 10'd880, 5'b00001), 1'b0);
    do_buy(3'd0, 10'd1000, 7'd100, mk(0, 0, 1, 0, 10'd1000, 5'b00000), 1'b0);
    restock_valid = 1'b1;
    restock_item  = 3'd1;
    restock_qty   = 3'd7;
    @(posedge clk); #1;
    restock_valid = 1'b0;
    for (int k = 0; k < 7; k++)
      do_buy(3'd1, 10'd1000, 7'd10, mk(1, 0, 0, 0, 10'd980, 5'b00010), 1'b0);
    do_buy(3'd1, 10'd1000, 7'd10, mk(0, 0, 1, 0, 10'd1000, 5'b00000), 1'b0);
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/param_shop.md
PARAM_SHOP -- requirements
Module: param_shop

Interface
REQ-001 SHALL take parameters: N_ITEMS, default 5, item count; ACT_W, default 3, action field width (2^ACT_W >= N_ITEMS); PRICE_W, default 10, price width; CREDIT_W, default 10, credit width; STOCK_W, default 3, stock counter width; STOCK_INIT, default 5, per-item stock after reset.
REQ-002 SHALL have ports, one per line: name direction width meaning.
- clk  in  1  single clock; all logic on posedge
- rst_n  in  1  reset, synchronous, active-low
- buy_valid  in  1  purchase request valid
- buy_ready  out  1  block can accept a request
- action_number  in  ACT_W  item index
- credit_in  in  CREDIT_W  player credit at request
- discount_mult  in  7  price multiplier, percent
- prices  in  N_ITEMS*PRICE_W  flattened price table; item i at bits [i*PRICE_W +: PRICE_W]
- restock_valid  in  1  restock request (present only with SHOP_RESTOCK_EN)
- restock_item  in  ACT_W  item to restock (SHOP_RESTOCK_EN only)
- restock_qty  in  STOCK_W  quantity to add (SHOP_RESTOCK_EN only)
- resp_valid  out  1  one-cycle pulse; response fields valid
- purchase_success  out  1  purchase completed
- err_invalid_action  out  1  action_number >= N_ITEMS
- err_out_of_stock  out  1  selected item stock is 0
- err_credit  out  1  discounted price > credit
- credit_out  out  CREDIT_W  credit after transaction
- grant_onehot  out  N_ITEMS  one-hot granted item
- empty_mask  out  N_ITEMS  bit i = stock[i]==0, registered

Function
REQ-003 SHALL be a 3-state FSM: IDLE, CALC, RESP; buy_ready = 1 only in IDLE.
REQ-004 SHALL accept a request on posedge with buy_valid && buy_ready: latch action, credit_in, discount_mult, selected price; go to CALC. buy_valid outside IDLE SHALL be ignored (no queueing).
REQ-005 In CALC SHALL compute disc_price = (price * min(discount_mult,100)) / 100, truncated, full-width intermediate (PRICE_W+7 bits); go to RESP.
REQ-006 On the RESP edge SHALL register the result and pulse resp_valid for exactly one cycle, 2 cycles after the accepting edge; return to IDLE.
REQ-007 Error priority: invalid action > out of stock > credit; exactly one of purchase_success/err_* set while resp_valid=1.
REQ-008 On success: credit_out = credit - disc_price, grant_onehot bit set for action, stock[action] decremented once.
REQ-009 On any error: credit_out = latched credit, grant_onehot = 0, stock unchanged.
REQ-010 disc_price == credit SHALL succeed with credit_out = 0; disc_price 0 SHALL succeed if stock > 0.
REQ-011 Outside resp_valid, purchase_success, err_*, grant_onehot SHALL be 0; credit_out SHALL hold its last value.
REQ-012 prices and credit_in changes after acceptance SHALL NOT affect an in-flight transaction.

Reset
REQ-013 On posedge with rst_n=0: state IDLE, every stock = STOCK_INIT, resp_valid/purchase_success/err_*/grant_onehot = 0, credit_out = 0, empty_mask = 0 (or all-ones if STOCK_INIT = 0).
REQ-014 Reset in CALC or RESP SHALL abort the transaction: no resp_valid, no stock change.

Configuration
REQ-015 Macro SHOP_RESTOCK_EN defined: restock ports exist; restock_valid adds restock_qty to stock[restock_item] any cycle, saturating at 2^STOCK_W-1; restock_item >= N_ITEMS ignored; same-cycle purchase decrement and restock of one item nets to min(stock-1+qty, max). Undefined: restock ports absent, stock only decrements.

Verification
REQ-016 Defaults, prices {120,200,50,50,10}, credit 1000, mult 100, action 6 -> 2 cycles later resp_valid=1, err_invalid_action=1, credit_out=1000.
REQ-017 Action 1, credit 50 -> err_credit=1, purchase_success=0, credit_out=50.
REQ-018 Action 0, credit 1000 -> purchase_success=1, credit_out=880, grant_onehot=00001; five more buys of item 0 feeding back credit_out -> 5th total OK (400), 6th err_out_of_stock=1, credit_out=400, empty_mask[0]=1.
REQ-019 After reset, mult 80, action 0, credit 1000 -> credit_out=904; mult 120 -> treated as 100, credit_out=880.
REQ-020 SHOP_RESTOCK_EN: item 0 drained to 0, restock_qty 3 on the RESP edge of a buy of item 2 -> stock[0]=3, empty_mask[0]=0; restock_qty 7 on full stock saturates at 7.
REQ-021 buy_valid held high in CALC -> no second acceptance until IDLE; rst_n=0 in CALC -> no resp_valid, stock[action] still 5.
